// File: rtl/mem_arbiter_ctrl.sv
// Two-port round-robin arbiter and setup/access sequencer for the JK-flip-flop word memory.
// Every output is a register; the memory lines are only active during SETUP and ACCESS.
module mem_arbiter_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              rw0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [WORDS-1:0]  mem_add,
   output logic              mem_rw,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_r;
   logic              ptr_r;
   logic              owner_r;
   logic              rw_r;
   logic              any_req_s;
   logic              win_s;
   logic              win_rw_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [DATA_W-1:0] win_wdata_s;

   function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
      logic [WORDS-1:0] v;
      v    = {WORDS{1'b0}};
      v[a] = 1'b1;
      return v;
   endfunction

   // Arbitration: a lone requester wins outright, a tie goes to the pointer.
   always_comb begin
      any_req_s = req0 | req1;
      if (req0 && req1) begin
         win_s = ptr_r;
      end else if (req1) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
      if (win_s) begin
         win_rw_s    = rw1;
         win_addr_s  = addr1;
         win_wdata_s = wdata1;
      end else begin
         win_rw_s    = rw0;
         win_addr_s  = addr0;
         win_wdata_s = wdata0;
      end
   end

   // Sequencer: command latched at the IDLE edge, then fixed SETUP/ACCESS/DONE walk.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         ptr_r     <= 1'b0;
         owner_r   <= 1'b0;
         rw_r      <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         busy      <= 1'b0;
         rdata     <= {DATA_W{1'b0}};
         mem_add   <= {WORDS{1'b0}};
         mem_rw    <= 1'b0;
         mem_wdata <= {DATA_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  owner_r   <= win_s;
                  rw_r      <= win_rw_s;
                  gnt0      <= ~win_s;
                  gnt1      <= win_s;
                  busy      <= 1'b1;
                  mem_add   <= onehot(win_addr_s);
                  mem_wdata <= win_wdata_s;
                  mem_rw    <= 1'b0;
                  state_r   <= ST_SETUP;
               end else begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               mem_rw  <= rw_r;
               state_r <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // The memory's read path is still selected on this edge.
               if (!rw_r) begin
                  rdata <= mem_rdata;
               end else begin
                  rdata <= rdata;
               end
               mem_add <= {WORDS{1'b0}};
               mem_rw  <= 1'b0;
               ack0    <= ~owner_r;
               ack1    <= owner_r;
               ptr_r   <= ~owner_r;
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               gnt0    <= 1'b0;
               gnt1    <= 1'b0;
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               gnt0    <= 1'b0;
               gnt1    <= 1'b0;
               ack0    <= 1'b0;
               ack1    <= 1'b0;
               busy    <= 1'b0;
               mem_add <= {WORDS{1'b0}};
               mem_rw  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: word memory model, transaction-timing reference model,
// directed vector table, hand-written corner sequences and randomized traffic.
module tb_mem_arbiter_ctrl;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 2;
   localparam int WORDS  = 4;

   logic              clk;
   logic              reset;
   logic              req0, rw0, req1, rw1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, ack0, ack1, busy, mem_rw;
   logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
   logic [WORDS-1:0]  mem_add;
   logic              mem_clr;
   logic [DATA_W-1:0] bmem [WORDS];

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .busy(busy),
      .mem_add(mem_add), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Word memory: captures on the rising edge while selected with rw=1.
   always @(posedge clk) begin
      for (int w = 0; w < WORDS; w++) begin
         if (mem_clr) bmem[w] <= '0;
         else if (mem_rw && mem_add[w]) bmem[w] <= mem_wdata;
      end
   end

   // Read data is gated by the word select.
   always_comb begin
      mem_rdata = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (mem_add[w]) mem_rdata = mem_rdata | bmem[w];
      end
   end

   // Reference model: a transaction starts at edge m_start; its effects follow by edge count.
   int                cyc = 0;
   int                m_start = 0;
   bit                m_active = 1'b0;
   bit                m_owner = 1'b0, m_ptr = 1'b0, m_rw = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0, m_wdata_out = '0;
   logic [DATA_W-1:0] refmem [WORDS];
   bit                e_ack0, e_ack1, e_gnt0, e_gnt1;

   task automatic model_step();
      int d;
      cyc++;
      d = cyc - m_start;
      if (m_active && d == 2 && m_rw) refmem[m_addr] = m_wdata;
      if (reset) begin
         m_active    = 1'b0;
         m_ptr       = 1'b0;
         m_rdata     = '0;
         m_wdata_out = '0;
      end else begin
         if (m_active && d == 2) begin
            if (!m_rw) m_rdata = refmem[m_addr];
            m_ptr = !m_owner;
         end
         if ((!m_active || d >= 4) && (req0 || req1)) begin
            m_owner     = (req0 && req1) ? m_ptr : req1;
            m_rw        = m_owner ? rw1 : rw0;
            m_addr      = m_owner ? addr1 : addr0;
            m_wdata     = m_owner ? wdata1 : wdata0;
            m_wdata_out = m_wdata;
            m_active    = 1'b1;
            m_start     = cyc;
         end
      end
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_all();
      int               d;
      bit               on;
      logic [WORDS-1:0] e_add;
      d      = cyc - m_start;
      on     = m_active && d <= 2;
      e_gnt0 = on && !m_owner;
      e_gnt1 = on && m_owner;
      e_ack0 = m_active && d == 2 && !m_owner;
      e_ack1 = m_active && d == 2 && m_owner;
      e_add  = '0;
      if (m_active && d <= 1) e_add[m_addr] = 1'b1;
      cmp("gnt0", 32'(gnt0), 32'(e_gnt0));
      cmp("gnt1", 32'(gnt1), 32'(e_gnt1));
      cmp("ack0", 32'(ack0), 32'(e_ack0));
      cmp("ack1", 32'(ack1), 32'(e_ack1));
      cmp("busy", 32'(busy), 32'(on));
      cmp("mem_add", 32'(mem_add), 32'(e_add));
      cmp("mem_rw", 32'(mem_rw), 32'(m_active && d == 1 && m_rw));
      cmp("mem_wdata", 32'(mem_wdata), 32'(m_wdata_out));
      cmp("rdata", 32'(rdata), 32'(m_rdata));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   // Waits (bounded) for ack on a port; returns whether it came and after how many edges.
   task automatic wait_ack(input bit port, output bit seen, output int lat);
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 10) begin
         tick();
         lat++;
         seen = port ? ack1 : ack0;
      end
   endtask

   typedef struct {
      bit                port;
      bit                rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t vt [7];
   bit   seen;
   int   lat;
   int   n_rise;
   int   rise_cyc [8];
   bit   rise_own [8];
   bit   first_own;
   bit   p0, p1;

   initial begin
      vt[0] = '{1'b0, 1'b1, 2'd2, 4'b0101, 4'b0000};
      vt[1] = '{1'b1, 1'b0, 2'd2, 4'b0000, 4'b0101};
      vt[2] = '{1'b0, 1'b1, 2'd1, 4'b0111, 4'b0101};
      vt[3] = '{1'b0, 1'b0, 2'd1, 4'b0000, 4'b0111};
      vt[4] = '{1'b1, 1'b1, 2'd3, 4'b1010, 4'b0111};
      vt[5] = '{1'b0, 1'b0, 2'd3, 4'b0000, 4'b1010};
      vt[6] = '{1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
      for (int w = 0; w < WORDS; w++) refmem[w] = '0;

      // Reset held two cycles with both requesters asking.
      reset = 1'b1; mem_clr = 1'b1;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 2'd0; wdata0 = 4'd0;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 2'd0; wdata1 = 4'd0;
      tick();
      mem_clr = 1'b0;
      tick();
      cmp("rst_gnt", 32'({gnt0, gnt1, ack0, ack1, busy, mem_rw}), 32'd0);
      cmp("rst_mem_add", 32'(mem_add), 32'd0);
      cmp("rst_data", 32'({mem_wdata, rdata}), 32'd0);
      reset = 1'b0;
      tick();
      cmp("first_gnt", 32'({gnt0, gnt1}), 32'b10);
      req1 = 1'b0;
      wait_ack(1'b0, seen, lat);
      cmp("first_ack", 32'(seen), 32'd1);
      req0 = 1'b0;
      tick();

      // Directed single transactions from the vector table.
      for (int i = 0; i < 7; i++) begin
         if (vt[i].port) begin
            req1 = 1'b1; rw1 = vt[i].rw; addr1 = vt[i].addr; wdata1 = vt[i].wdata;
         end else begin
            req0 = 1'b1; rw0 = vt[i].rw; addr0 = vt[i].addr; wdata0 = vt[i].wdata;
         end
         wait_ack(vt[i].port, seen, lat);
         cmp("vec_ack_seen", 32'(seen), 32'd1);
         cmp("vec_latency", 32'(lat), 32'd3);
         cmp("vec_rdata", 32'(rdata), 32'(vt[i].exp_rdata));
         req0 = 1'b0; req1 = 1'b0;
         tick();
      end

      // Contention: both held high, grants must alternate every 4 cycles.
      first_own = m_ptr;
      req0 = 1'b1; rw0 = 1'b0; addr0 = 2'd1;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 2'd3;
      n_rise = 0; p0 = gnt0; p1 = gnt1;
      for (int k = 0; k < 17; k++) begin
         tick();
         if (n_rise < 8 && ((gnt0 && !p0) || (gnt1 && !p1))) begin
            rise_cyc[n_rise] = cyc;
            rise_own[n_rise] = gnt1;
            n_rise++;
         end
         p0 = gnt0; p1 = gnt1;
      end
      cmp("rr_rises", 32'(n_rise >= 4), 32'd1);
      for (int i = 0; i < n_rise; i++) begin
         cmp("rr_owner", 32'(rise_own[i]), 32'(first_own ^ i[0]));
         if (i > 0) cmp("rr_gap", 32'(rise_cyc[i] - rise_cyc[i-1]), 32'd4);
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 5; k++) tick();

      // Reset arriving during ACCESS of a write.
      req0 = 1'b1; rw0 = 1'b1; addr0 = 2'd3; wdata0 = 4'b1111;
      tick();
      tick();
      cmp("mid_access_rw", 32'(mem_rw), 32'd1);
      reset = 1'b1;
      tick();
      cmp("mid_rst_outs", 32'({gnt0, ack0, busy, mem_rw}), 32'd0);
      cmp("mid_rst_add", 32'(mem_add), 32'd0);
      reset = 1'b0;
      wait_ack(1'b0, seen, lat);
      cmp("regrant_ack", 32'(seen), 32'd1);
      cmp("regrant_lat", 32'(lat), 32'd3);
      req0 = 1'b0;
      tick();
      req1 = 1'b1; rw1 = 1'b0; addr1 = 2'd3;
      wait_ack(1'b1, seen, lat);
      cmp("regrant_read", 32'(rdata), 32'(4'b1111));
      req1 = 1'b0;
      tick();

      // Inputs changed after the latch point must not reach the memory.
      req0 = 1'b1; rw0 = 1'b1; addr0 = 2'd0; wdata0 = 4'b1100;
      tick();
      addr0 = 2'd3; wdata0 = 4'b0011;
      tick();
      cmp("stable_add", 32'(mem_add), 32'(4'b0001));
      cmp("stable_wdata", 32'(mem_wdata), 32'(4'b1100));
      tick();
      cmp("stable_ack", 32'(ack0), 32'd1);
      req0 = 1'b0;
      req1 = 1'b1; rw1 = 1'b0; addr1 = 2'd0;
      tick();
      cmp("late_req_idle", 32'(gnt1), 32'd0);
      tick();
      cmp("late_req_gnt", 32'(gnt1), 32'd1);
      wait_ack(1'b1, seen, lat);
      cmp("late_req_rdata", 32'(rdata), 32'(4'b1100));
      req1 = 1'b0;
      tick();

      // Randomized traffic obeying the hold-until-ack protocol.
      for (int k = 0; k < 400; k++) begin
         if (!req0) begin
            if ($urandom_range(2) == 0) begin
               req0 = 1'b1; rw0 = 1'($urandom_range(1));
               addr0 = ADDR_W'($urandom_range(WORDS - 1)); wdata0 = DATA_W'($urandom);
            end
         end else if (e_ack0) begin
            if ($urandom_range(1) == 0) req0 = 1'b0;
            rw0 = 1'($urandom_range(1));
            addr0 = ADDR_W'($urandom_range(WORDS - 1)); wdata0 = DATA_W'($urandom);
         end else if (e_gnt0 && $urandom_range(3) == 0) begin
            addr0 = ADDR_W'($urandom_range(WORDS - 1)); wdata0 = DATA_W'($urandom);
         end
         if (!req1) begin
            if ($urandom_range(2) == 0) begin
               req1 = 1'b1; rw1 = 1'($urandom_range(1));
               addr1 = ADDR_W'($urandom_range(WORDS - 1)); wdata1 = DATA_W'($urandom);
            end
         end else if (e_ack1) begin
            if ($urandom_range(1) == 0) req1 = 1'b0;
            rw1 = 1'($urandom_range(1));
            addr1 = ADDR_W'($urandom_range(WORDS - 1)); wdata1 = DATA_W'($urandom);
         end else if (e_gnt1 && $urandom_range(3) == 0) begin
            addr1 = ADDR_W'($urandom_range(WORDS - 1)); wdata1 = DATA_W'($urandom);
         end
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      for (int k = 0; k < 6; k++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
